// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode/execute control, instruction-memory req/ack port and IF/ID register outputs.
interface fetch_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             if_id_valid;
  logic [WIDTH-1:0] if_id_pc;
  logic [WIDTH-1:0] if_id_pc_plus4;
  logic [31:0]      if_id_instr;

  modport master (
    input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack handshake, IF/ID register with a one-entry stall buffer,
// and redirect handling that drains an in-flight request before refetching.
module fetch_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic    clk,
  input  logic    reset_n,
  fetch_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] drop_addr_q, drop_addr_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic [WIDTH-1:0] if_id_pc_q, if_id_pc_d;
  logic [WIDTH-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0]      if_id_instr_q, if_id_instr_d;
  logic             buf_valid_q, buf_valid_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]      buf_instr_q, buf_instr_d;

  logic             accept;
  logic             invalidate;
  logic [WIDTH-1:0] target;

  assign accept = !bus.stall || !if_id_valid_q;
  assign target = bus.redirect_pc & ALIGN_MASK;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    drop_addr_d      = drop_addr_q;
    if_id_valid_d    = if_id_valid_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_instr_d    = if_id_instr_q;
    buf_valid_d      = buf_valid_q;
    buf_pc_d         = buf_pc_q;
    buf_instr_d      = buf_instr_q;
    invalidate       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (bus.redirect) pc_d = target;
      end
      S_FETCH: begin
        if (bus.redirect) begin
          pc_d       = target;
          invalidate = 1'b1;
          // Request cannot be withdrawn: remember its address and wait out the ack.
          if (!bus.imem_ack) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (bus.imem_ack) begin
          pc_d = pc_q + PC_STEP;
          if (accept) begin
            if_id_valid_d    = 1'b1;
            if_id_pc_d       = pc_q;
            if_id_pc_plus4_d = pc_q + PC_STEP;
            if_id_instr_d    = bus.imem_rdata;
          end else begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_q;
            buf_instr_d = bus.imem_rdata;
            state_d     = S_HOLD;
          end
        end else if (!bus.stall) begin
          invalidate = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.redirect) begin
          pc_d        = target;
          buf_valid_d = 1'b0;
          invalidate  = 1'b1;
          state_d     = S_FETCH;
        end else if (!bus.stall) begin
          if_id_valid_d    = buf_valid_q;
          if_id_pc_d       = buf_pc_q;
          if_id_pc_plus4_d = buf_pc_q + PC_STEP;
          if_id_instr_d    = buf_instr_q;
          buf_valid_d      = 1'b0;
          state_d          = S_FETCH;
        end
      end
      S_DROP: begin
        if (bus.redirect) pc_d = target;
        if (bus.imem_ack) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    if (invalidate) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      pc_q             <= RESET_PC;
      drop_addr_q      <= RESET_PC;
      if_id_valid_q    <= 1'b0;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_instr_q    <= NOP_INSTR;
      buf_valid_q      <= 1'b0;
      buf_pc_q         <= '0;
      buf_instr_q      <= NOP_INSTR;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      drop_addr_q      <= drop_addr_d;
      if_id_valid_q    <= if_id_valid_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_instr_q    <= if_id_instr_d;
      buf_valid_q      <= buf_valid_d;
      buf_pc_q         <= buf_pc_d;
      buf_instr_q      <= buf_instr_d;
    end
  end

  assign bus.imem_req       = (state_q == S_FETCH) || (state_q == S_DROP);
  assign bus.imem_addr      = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign bus.if_id_valid    = if_id_valid_q;
  assign bus.if_id_pc       = if_id_pc_q;
  assign bus.if_id_pc_plus4 = if_id_pc_plus4_q;
  assign bus.if_id_instr    = if_id_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect/wait-state traffic,
// checked by a request-level scoreboard of which fetched words must reach IF/ID and in what order.
module tb_fetch_stage;
  localparam int          W   = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.WIDTH(W)) bus ();
  fetch_if #(.WIDTH(W)) bus2 ();

  fetch_stage #(.WIDTH(W), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  fetch_stage #(.WIDTH(W), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .bus(bus2));

  int checks = 0;
  int failures = 0;
  int deliveries = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- memory models ----------------
  int   wait_mode = 0;          // <0: random 0..3 wait cycles per request
  bit   force_ack = 1'b0;
  logic mem_ack = 1'b0;
  bit   m_active = 1'b0;
  bit   m_ack_seen = 1'b0;
  int   m_waited = 0;
  int   m_need = 0;

  assign bus.imem_ack    = mem_ack | force_ack;
  assign bus.imem_rdata  = bus.imem_addr | 32'h13;
  assign bus2.imem_ack   = bus2.imem_req;
  assign bus2.imem_rdata = bus2.imem_addr | 32'h13;

  initial begin
    forever begin
      @(posedge clk);
      m_ack_seen = bus.imem_ack;
      #1;
      if (m_ack_seen || !bus.imem_req) m_active = 1'b0;
      if (bus.imem_req && !m_active) begin
        m_active = 1'b1;
        m_waited = 0;
        m_need   = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
      end else if (m_active) begin
        m_waited++;
      end
      mem_ack = m_active && (m_waited >= m_need);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];
  bit          tainted = 1'b0;
  bit          held = 1'b0;
  bit          redir_prev = 1'b0;
  bit          rst_prev = 1'b1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] sv_pc = '0, sv_p4 = '0, sv_instr = '0;
  logic [31:0] exp_pc;
  logic [1:0]  addr_lo;

  initial begin
    forever begin
      @(negedge clk);
      // Outputs now reflect the edge that consumed last cycle's recorded inputs.
      if (rst_prev) begin
        check("rst_valid", bus.if_id_valid, 0);
        check("rst_pc", bus.if_id_pc, 0);
        check("rst_pc4", bus.if_id_pc_plus4, 0);
        check("rst_instr", bus.if_id_instr, NOP);
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 32'h0);
      end else begin
        if (redir_prev) check("redirect_bubble", bus.if_id_valid, 0);
        if (!bus.if_id_valid) begin
          check("bubble_instr", bus.if_id_instr, NOP);
        end else if (held) begin
          check("stall_hold_pc", bus.if_id_pc, sv_pc);
          check("stall_hold_pc4", bus.if_id_pc_plus4, sv_p4);
          check("stall_hold_instr", bus.if_id_instr, sv_instr);
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery actual_pc=%h required=none", bus.if_id_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          deliveries++;
          check("deliver_pc", bus.if_id_pc, exp_pc);
          check("deliver_pc4", bus.if_id_pc_plus4, exp_pc + 32'd4);
          check("deliver_instr", bus.if_id_instr, exp_pc | 32'h13);
        end
        if (pend) begin
          check("req_stable", bus.imem_req, 1);
          check("addr_stable", bus.imem_addr, pend_addr);
        end
      end
      addr_lo = bus.imem_addr[1:0];
      check("addr_aligned", {30'd0, addr_lo}, 0);

      // Record what the coming edge will consume.
      sv_pc    = bus.if_id_pc;
      sv_p4    = bus.if_id_pc_plus4;
      sv_instr = bus.if_id_instr;
      rst_prev = !reset_n;
      if (!reset_n) begin
        exp_q.delete();
        tainted    = 1'b0;
        held       = 1'b0;
        redir_prev = 1'b0;
        pend       = 1'b0;
      end else begin
        held       = bus.if_id_valid && bus.stall && !bus.redirect;
        redir_prev = bus.redirect;
        if (bus.redirect) exp_q.delete();
        if (bus.imem_req) begin
          // A request that overlaps a redirect returns data nobody may see.
          if (bus.redirect) tainted = 1'b1;
          if (bus.imem_ack) begin
            if (!tainted) exp_q.push_back(bus.imem_addr);
            tainted = 1'b0;
          end
        end
        pend      = bus.imem_req && !bus.imem_ack;
        pend_addr = bus.imem_addr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc_v);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.if_id_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_valid required=valid", name);
    end else begin
      check(name, bus.if_id_pc, exp_pc_v);
    end
  endtask

  logic [31:0] abandoned;
  bit          found;

  initial begin
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.redirect_pc = '0;

    // Reset, zero-wait memory, then a 3-cycle stall while IF/ID holds pc 8.
    wait_mode = 0;
    repeat (3) step();
    reset_n = 1'b1;
    check("idle_req", bus.imem_req, 0);
    step();
    check("first_req", bus.imem_req, 1);
    check("first_addr", bus.imem_addr, 32'h0);
    check("first_not_valid", bus.if_id_valid, 0);
    step();
    check("seq0_valid", bus.if_id_valid, 1);
    check("seq0_pc", bus.if_id_pc, 32'h0);
    check("wrap0_valid", bus2.if_id_valid, 1);
    check("wrap0_pc", bus2.if_id_pc, 32'hFFFF_FFFC);
    check("wrap0_pc4", bus2.if_id_pc_plus4, 32'h0);
    check("wrap0_instr", bus2.if_id_instr, 32'hFFFF_FFFF);
    step();
    check("seq1_pc", bus.if_id_pc, 32'h4);
    check("wrap1_pc", bus2.if_id_pc, 32'h0);
    check("wrap1_pc4", bus2.if_id_pc_plus4, 32'h4);
    step();
    check("seq2_pc", bus.if_id_pc, 32'h8);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc8", bus.if_id_pc, 32'h8);
      check("stall_req_low", bus.imem_req, 0);
    end
    bus.stall = 1'b0;
    step();
    check("after_stall_pc12", bus.if_id_pc, 32'hC);
    check("after_stall_valid", bus.if_id_valid, 1);
    step();
    check("after_stall_pc16", bus.if_id_pc, 32'h10);

    // 2-wait memory, redirect one cycle into the request to 0x10.
    reset_n = 1'b0;
    wait_mode = 2;
    repeat (2) step();
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.imem_req && bus.imem_addr == 32'h10) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL req_0x10_timeout actual=none required=%h", 32'h10);
    end
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    check("drop_req", bus.imem_req, 1);
    check("drop_addr", bus.imem_addr, 32'h10);
    check("drop_bubble_instr", bus.if_id_instr, NOP);
    step();
    check("post_drop_addr", bus.imem_addr, 32'h100);
    wait_valid("target_pc_0x100", 32'h100);

    // Redirect together with stall while holding a buffered instruction.
    wait_mode = 0;
    repeat (6) step();
    check("hold_pre_valid", bus.if_id_valid, 1);
    bus.stall = 1'b1;
    step();
    check("hold_req_low", bus.imem_req, 0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h203;
    step();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    check("hold_redir_valid", bus.if_id_valid, 0);
    check("hold_redir_instr", bus.if_id_instr, NOP);
    check("hold_redir_req", bus.imem_req, 1);
    check("hold_redir_addr", bus.imem_addr, 32'h200);
    repeat (4) step();

    // Reset pulse while in DROP, with a stale ack during reset.
    wait_mode = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      if (bus.imem_req && !bus.imem_ack) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL pending_req_timeout actual=none required=pending");
    end
    abandoned = bus.imem_addr;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    check("drop2_req", bus.imem_req, 1);
    check("drop2_addr", bus.imem_addr, abandoned);
    reset_n = 1'b0;
    force_ack = 1'b1;
    step();
    reset_n = 1'b1;
    force_ack = 1'b0;
    check("drop_rst_req", bus.imem_req, 0);
    check("drop_rst_valid", bus.if_id_valid, 0);
    check("drop_rst_instr", bus.if_id_instr, NOP);
    step();
    check("restart_addr", bus.imem_addr, 32'h0);
    wait_valid("restart_pc", 32'h0);

    // Random traffic.
    wait_mode = -1;
    for (int i = 0; i < 1500; i++) begin
      step();
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.redirect    = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = $urandom;
    end
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    repeat (30) step();
    checks++;
    if (deliveries < 100) begin
      failures++;
      $display("FAIL delivery_count actual=%0d required>=100", deliveries);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly upstream of `data_path`: owns the program counter, runs a req/ack handshake with instruction memory, and drives the IF/ID pipeline register consumed by the decode stage. It absorbs decode stalls through a one-entry holding buffer. It also handles branch/jump redirects from execute, including redirects that arrive while a memory request is still outstanding.

## Interface
- `WIDTH`, 32, address/data width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, instruction value used for bubbles (addi x0,x0,0)

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous, active-low reset
- `stall`  in  1  decode cannot accept; hold IF/ID
- `redirect`  in  1  taken branch/jump from execute
- `redirect_pc`  in  WIDTH  redirect target; bits [1:0] forced to 0
- `imem_req`  out  1  fetch request
- `imem_addr`  out  WIDTH  fetch address, word-aligned
- `imem_ack`  in  1  instruction valid this cycle; same-cycle ack allowed
- `imem_rdata`  in  32  fetched instruction
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `if_id_pc`  out  WIDTH  PC of IF/ID instruction
- `if_id_pc_plus4`  out  WIDTH  `if_id_pc`+4, mod 2^WIDTH
- `if_id_instr`  out  32  instruction, `NOP_INSTR` when invalid

## Operation
- Reset values: state IDLE, `pc`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_id_valid`=0, `if_id_pc`=0, `if_id_pc_plus4`=0, `if_id_instr`=`NOP_INSTR`, buffer invalid. `imem_ack` is ignored while reset is low.
- `imem_req` is a Moore output: 1 in FETCH and DROP, 0 otherwise. `imem_addr`=`pc`, except in DROP, where it holds the abandoned address.
- Once raised, `imem_req`/`imem_addr` stay stable until `imem_ack`. A request is never withdrawn.
- "Accept" means `!stall || !if_id_valid`.
- IDLE: always goes to FETCH on the next cycle.
- FETCH:
  - `redirect` with no ack: go to DROP. `pc`←target. IF/ID is invalidated.
  - `redirect` with ack: data is discarded. `pc`←target. IF/ID is invalidated. Stay in FETCH.
  - Ack with accept: IF/ID←{1, pc, pc+4, rdata}, `pc`←pc+4.
  - Ack without accept: buffer←{pc, rdata}, `pc`←pc+4, go to HOLD.
  - No ack: stay. If `!stall`, IF/ID is invalidated (bubble).
- HOLD:
  - `redirect`: buffer and IF/ID are invalidated. `pc`←target. Go to FETCH.
  - `!stall`: IF/ID←buffer, buffer invalidated, go to FETCH.
  - Otherwise hold.
- DROP:
  - Wait for ack; the returned data is discarded, then go to FETCH at `pc`.
  - A further `redirect` while in DROP overwrites `pc` only.
  - IF/ID stays invalid.
- `redirect` has priority over `stall` in every state.
- Invalidating IF/ID clears `if_id_valid` and loads `if_id_instr`=`NOP_INSTR`. `if_id_pc` and `if_id_pc_plus4` are don't-care.
- With `stall`=1 and `if_id_valid`=1, all IF/ID fields hold unchanged.
- PC increments wrap modulo 2^WIDTH.

## Timing
- Reset release at edge N: IDLE during cycle N. First `imem_req` in cycle N+1.
- Zero-wait memory (ack in same cycle as req): `if_id_valid` goes high one cycle after the ack. Sustained throughput is 1 instruction/cycle.
- Memory with k wait cycles: one instruction per k+1 cycles, with bubbles between.
- Redirect:
  - Redirect asserted at cycle R: IF/ID is a bubble at R+1.
  - With zero-wait memory, the target instruction is in IF/ID at R+2.
  - If a request was outstanding, add the remaining cycles until its ack plus one.
- Stall: no instruction is lost or duplicated. At most one instruction is buffered.
- Reset low mid-operation: all state returns to reset values at the next edge, including DROP and HOLD.

## Test plan
- Reset, zero-wait memory returning `rdata`=addr|0x13: IF/ID shows pc 0,4,8,12 on consecutive cycles. `if_id_pc_plus4` = pc+4. First valid appears 2 cycles after reset release.
- `stall`=1 for 3 cycles while IF/ID holds pc 8: IF/ID holds pc 8. pc 12 goes to the buffer and `imem_req` drops. After release, IF/ID shows 12 then 16, with no gaps or duplicates.
- 2-wait-cycle memory:
  - `redirect` to 0x100 one cycle after a request to 0x10 is issued.
  - Required: `imem_addr` stays 0x10 until ack and that data is dropped.
  - Required: the next request is to 0x100, and IF/ID first shows pc 0x100.
- `redirect` to 0x203 asserted together with `stall`=1 in HOLD: buffer is discarded. IF/ID is a bubble with `if_id_instr`=0x13. The next fetch address is 0x200.
- `RESET_PC`=0xFFFF_FFFC: sequence is 0xFFFF_FFFC then 0x0000_0000. `if_id_pc_plus4`=0 for the first instruction.
- `reset_n` pulled low for 1 cycle while in DROP: all outputs return to reset values. Fetch restarts at `RESET_PC`, and a stale ack during reset is ignored.
